// File: rtl/console_pkg.sv
// rtl/console_pkg.sv - shared fetch-state encoding and control-word field helpers
package console_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_LO = 2'd1,
        RD_HI = 2'd2,
        CAP   = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Field views of the assembled control word as seen by the decoder.
    function automatic logic [1:0] cw_opvar(input logic [31:0] w);
        return w[1:0];
    endfunction

    function automatic logic [4:0] cw_opcode(input logic [31:0] w);
        return w[6:2];
    endfunction

    function automatic logic [2:0] cw_op1(input logic [31:0] w);
        return w[9:7];
    endfunction

    function automatic logic [2:0] cw_op2(input logic [31:0] w);
        return w[12:10];
    endfunction

    function automatic logic [2:0] cw_res(input logic [31:0] w);
        return w[15:13];
    endfunction

    function automatic logic [15:0] cw_word2(input logic [31:0] w);
        return w[31:16];
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - two-word ROM fetch with single-entry tag, NOP/stall while a fetch is outstanding
module instr_fetch #(
    parameter int          PC_W     = 16,
    parameter logic [31:0] NOP_WORD = console_pkg::NOP_WORD,
    parameter int          CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [PC_W-1:0]   pc,
    input  logic              flush,
    output logic [PC_W:0]     rom_addr,
    output logic              rom_en,
    input  logic [15:0]       rom_data,
    output logic [31:0]       cw,
    output logic              cw_valid,
    output logic              stall,
    output logic [CNT_W-1:0]  miss_count
);
    import console_pkg::*;

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [PC_W-1:0]   r_req_pc;
    logic [PC_W-1:0]   r_tag_pc;
    logic              r_tag_valid;
    logic [15:0]       r_lo_buf;
    logic [31:0]       r_cw;
    logic [CNT_W-1:0]  r_miss_count;

    logic              w_hit;
    logic              w_miss;
    logic              w_redirect;
    logic              w_restart;
    logic              w_rom_en;
    logic              w_half;

    assign w_hit      = r_tag_valid && (pc == r_tag_pc);
    assign w_miss     = flush || !w_hit;
    assign w_redirect = flush || (pc != r_req_pc);

    always_comb begin
        w_state_nxt = r_state;
        w_restart   = 1'b0;
        w_rom_en    = 1'b0;
        w_half      = 1'b0;
        case (r_state)
            IDLE: begin
                w_restart = w_miss;
            end
            RD_LO: begin
                w_rom_en    = 1'b1;
                w_restart   = w_redirect;
                w_state_nxt = RD_HI;
            end
            RD_HI: begin
                w_rom_en    = 1'b1;
                w_half      = 1'b1;
                w_restart   = w_redirect;
                w_state_nxt = CAP;
            end
            CAP: begin
                w_restart   = w_redirect;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        // Any miss or redirect always begins a fresh fetch of the current pc.
        if (w_restart) begin
            w_state_nxt = RD_LO;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= IDLE;
            r_req_pc     <= '0;
            r_tag_pc     <= '0;
            r_tag_valid  <= 1'b0;
            r_lo_buf     <= '0;
            r_cw         <= NOP_WORD;
            r_miss_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_restart) begin
                r_req_pc    <= pc;
                r_tag_valid <= 1'b0;
                if (r_miss_count != {CNT_W{1'b1}}) begin
                    r_miss_count <= r_miss_count + 1'b1;
                end
            end
            if (r_state == RD_HI) begin
                r_lo_buf <= rom_data;
            end
            if ((r_state == CAP) && !w_restart) begin
                r_cw        <= {rom_data, r_lo_buf};
                r_tag_pc    <= r_req_pc;
                r_tag_valid <= 1'b1;
            end
        end
    end

    assign cw_valid   = w_hit && !flush;
    assign stall      = !cw_valid;
    assign cw         = cw_valid ? r_cw : NOP_WORD;
    assign rom_en     = w_rom_en;
    assign rom_addr   = {r_req_pc, w_half};
    assign miss_count = r_miss_count;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch against a cycle-count reference model
module tb_instr_fetch;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] pc;
    logic        flush;
    logic [16:0] rom_addr;
    logic        rom_en;
    logic [15:0] rom_data;
    logic [31:0] cw;
    logic        cw_valid;
    logic        stall;
    logic [15:0] miss_count;

    int checks = 0;
    int errors = 0;

    instr_fetch #(.PC_W(16), .NOP_WORD(32'h0000_0000), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .pc(pc), .flush(flush),
        .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
        .cw(cw), .cw_valid(cw_valid), .stall(stall), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] rom_word(input logic [16:0] a);
        if (a == 17'h0) return 16'h0019;
        if (a == 17'h1) return 16'h1234;
        return a[15:0] ^ 16'hA5C3 ^ {a[7:0], a[16:9]};
    endfunction

    function automatic logic [31:0] exp_cw(input logic [15:0] p);
        return {rom_word({p, 1'b1}), rom_word({p, 1'b0})};
    endfunction

    // Synchronous ROM; garbage when not enabled so unsampled cycles are exercised.
    always @(posedge CLK) begin
        rom_data <= rom_en ? rom_word(rom_addr) : 16'($urandom);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a fetch takes three uninterrupted cycles on one pc.
    logic        m_cv;
    logic [15:0] m_cpc;
    logic        m_f;
    logic [15:0] m_fpc;
    int          m_e;
    int          m_miss;
    logic [31:0] sb[$];

    initial begin : model
        forever begin
            @(posedge CLK or posedge RST);
            if (RST) begin
                m_cv = 1'b0; m_cpc = '0; m_f = 1'b0; m_fpc = '0; m_e = 0; m_miss = 0;
                sb.delete();
            end else if ((m_f && (flush || pc != m_fpc)) ||
                         (!m_f && (flush || !m_cv || pc != m_cpc))) begin
                m_cv = 1'b0; m_f = 1'b1; m_fpc = pc; m_e = 0;
                if (m_miss < 65535) m_miss++;
            end else if (m_f) begin
                m_e++;
                if (m_e == 3) begin
                    m_f = 1'b0; m_cv = 1'b1; m_cpc = m_fpc;
                    sb.push_back(exp_cw(m_fpc));
                end
            end
        end
    end

    initial begin : monitor
        logic ev;
        logic prev_valid;
        logic [31:0] e;
        prev_valid = 1'b0;
        forever begin
            @(negedge CLK);
            ev = m_cv && (pc == m_cpc) && !flush;
            chk("cw_valid", cw_valid, ev);
            chk("stall", stall, !ev);
            if (!ev) chk("cw_nop", cw, 32'h0);
            chk("rom_en", rom_en, m_f && (m_e < 2));
            if (!m_f || m_e < 2) chk("rom_addr", rom_addr, {m_fpc, m_f && (m_e == 1)});
            chk("miss_count", miss_count, m_miss);
            if (cw_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_valid", 1, 0);
                end else begin
                    e = sb.pop_back();
                    sb.delete();
                    chk("sb_cw", cw, e);
                end
            end
            prev_valid = cw_valid;
        end
    end

    task automatic seg(input logic [15:0] p, input logic f, input int n);
        pc = p; flush = f;
        @(posedge CLK); #1;
        flush = 1'b0;
        repeat (n - 1) begin @(posedge CLK); #1; end
    endtask

    task automatic fill_addrs(input logic [15:0] p);
        logic [16:0] q[$];
        pc = p;
        repeat (5) begin
            @(negedge CLK);
            if (rom_en) q.push_back(rom_addr);
        end
        chk("addr_count", q.size(), 2);
        if (q.size() == 2) begin
            chk("addr_lo", q[0], {p, 1'b0});
            chk("addr_hi", q[1], {p, 1'b1});
        end
        chk("fill_valid", cw_valid, 1);
        chk("fill_cw", cw, exp_cw(p));
        @(posedge CLK); #1;
    endtask

    initial begin : stim
        int r;
        RST = 1'b1; pc = 16'h0; flush = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_cw", cw, 32'h0);
        chk("rst_valid", cw_valid, 0);
        chk("rst_stall", stall, 1);
        chk("rst_rom_en", rom_en, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_miss", miss_count, 0);

        @(posedge CLK); #1; RST = 1'b0;
        repeat (3) begin @(posedge CLK); #1; end
        chk("first_stall", stall, 1);
        @(posedge CLK); #1;
        chk("first_valid", cw_valid, 1);
        chk("first_cw", cw, 32'h1234_0019);
        chk("first_miss", miss_count, 1);

        repeat (10) begin
            @(negedge CLK);
            chk("hold_rom_en", rom_en, 0);
            chk("hold_cw", cw, 32'h1234_0019);
            chk("hold_miss", miss_count, 1);
        end
        @(posedge CLK); #1;

        seg(16'h0005, 1'b0, 2);
        seg(16'h0009, 1'b0, 5);
        chk("redir_cw", cw, {rom_word(17'h13), rom_word(17'h12)});
        chk("redir_miss", miss_count, 3);

        seg(16'h0003, 1'b0, 5);
        flush = 1'b1; #1;
        chk("flush_drop", cw_valid, 0);
        @(posedge CLK); #1; flush = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end
        chk("flush_stall", stall, 1);
        @(posedge CLK); #1;
        chk("flush_valid", cw_valid, 1);
        chk("flush_cw", cw, {rom_word(17'h7), rom_word(17'h6)});

        fill_addrs(16'hFFFF);
        fill_addrs(16'h0000);

        pc = 16'h0042;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        #2 RST = 1'b1; #1;
        chk("arst_cw", cw, 32'h0);
        chk("arst_valid", cw_valid, 0);
        chk("arst_stall", stall, 1);
        chk("arst_miss", miss_count, 0);
        chk("arst_rom_en", rom_en, 0);
        @(posedge CLK); #1; RST = 1'b0; pc = 16'h0077;
        repeat (3) begin @(posedge CLK); #1; end
        chk("arst_refill_stall", stall, 1);
        @(posedge CLK); #1;
        chk("arst_refill_valid", cw_valid, 1);
        chk("arst_refill_cw", cw, exp_cw(16'h0077));
        chk("arst_refill_miss", miss_count, 1);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            seg((r < 3) ? pc : (r == 3) ? 16'hFFFF : (r == 4) ? 16'h0000 : 16'($urandom_range(0, 15)),
                ($urandom_range(0, 4) == 0), $urandom_range(1, 7));
        end
        seg(pc, 1'b0, 6);

        @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Sits directly upstream of the control decoder. Takes the program counter (`romAdd`) and reads two consecutive 16-bit ROM words. Assembles them into the 32-bit `controlWord` the decoder consumes.
- Holds the last fetched instruction in a single-entry tag register, so an unchanged PC causes no refetch.
- While a fetch is outstanding it presents a NOP word and asserts `stall`, which the top level uses to freeze PC advance and register writeback.

Parameters:
- PC_W, 16, program counter width.
- NOP_WORD, 32'h0000_0000, word driven on `cw` while invalid (opcode 0 = NOP).
- CNT_W, 16, width of the saturating miss counter.

Ports:
- CLK  in  1  system clock; all state changes on posedge.
- RST  in  1  asynchronous, active-high reset.
- pc  in  PC_W  program counter from the control decoder.
- flush  in  1  invalidates the tag; forces a refetch of the current pc.
- rom_addr  out  PC_W+1  ROM word address, {req_pc, half}.
- rom_en  out  1  ROM read strobe.
- rom_data  in  16  synchronous ROM read data, valid the cycle after address/en.
- cw  out  32  assembled control word; [15:0] = word at {pc,0}, [31:16] = word at {pc,1}.
- cw_valid  out  1  `cw` corresponds to the current pc.
- stall  out  1  equals ~cw_valid.
- miss_count  out  CNT_W  number of fetches started, saturating.

Behaviour:
- Reset (async, any state): state=IDLE, tag_valid=0, req_pc=0, lo_buf=0, cw_reg=NOP_WORD, miss_count=0.
  - Outputs during reset: cw=NOP_WORD, cw_valid=0, stall=1, rom_en=0, rom_addr=0.
- Miss definition: miss = flush | ~tag_valid | (pc != tag_pc).
- States: IDLE, RD_LO, RD_HI, CAP.
- IDLE:
  - rom_en=0; rom_addr={req_pc,0}.
  - On miss: latch req_pc=pc, clear tag_valid, go to RD_LO, increment miss_count (saturating at all-ones).
  - No miss: stay in IDLE.
- RD_LO: rom_en=1, rom_addr={req_pc,0}; go to RD_HI.
- RD_HI: rom_en=1, rom_addr={req_pc,1}; capture lo_buf=rom_data; go to CAP.
- CAP: rom_en=0; capture cw_reg={rom_data, lo_buf}, tag_pc=req_pc, tag_valid=1; go to IDLE.
- Latency: pc change sampled at edge N gives cw_valid=1 from edge N+3, i.e. 3 cycles of stall per miss. A hit gives 0 cycles and no ROM activity.
- cw_valid = tag_valid & (pc == tag_pc) & ~flush. This is combinational, so a pc change drops cw_valid in the same cycle.
- cw = cw_valid ? cw_reg : NOP_WORD.
- Redirect: if pc != req_pc, or flush=1, in RD_LO, RD_HI or CAP:
  - Abort the fetch: no cw_reg or tag update.
  - Latch req_pc=pc and go to RD_LO; miss_count increments.
- Flush held high: the fetch restarts every cycle and never completes. Flush must be a single-cycle pulse.
- Simultaneous flush and pc change in IDLE: treated as one miss, one increment.
- pc wrap 0xFFFF to 0x0000: ordinary miss. rom_addr is PC_W+1 bits, so {0xFFFF,1}=0x1FFFF does not overflow.
- rom_data is sampled only in RD_HI and CAP; other cycles are ignored.

Decomposition:
- Shared package `console_pkg`:
  - fetch state enum (IDLE/RD_LO/RD_HI/CAP, 2 bits),
  - NOP_WORD constant,
  - control-word field slices (opvar [1:0], opcode [6:2], op1 [9:7], op2 [12:10], res [15:13], word2 [31:16]).
- Single module; no sub-module. The saturating counter is inline.

Test Plan:
- Reset then pc=0x0000 with ROM[0]=0x0019, ROM[1]=0x1234:
  - stall=1 for 3 cycles;
  - then cw=0x1234_0019, cw_valid=1;
  - miss_count=1.
- Hold pc=0x0000 for 10 cycles after a fill → rom_en stays 0, cw unchanged, miss_count stays 1.
- Redirect: pc=0x0005 mid-fetch (in RD_HI), then pc=0x0009 → the fetch aborts. Final cw={ROM[0x13],ROM[0x12]}, miss_count +2, no intermediate cw_valid pulse.
- Flush pulse with pc unchanged at 0x0003 → cw_valid=0 in the same cycle; refetch of ROM[6]/ROM[7]; valid again 3 cycles later.
- pc=0xFFFF → rom_addr sequence 0x1FFFE, 0x1FFFF. Then pc=0x0000 → rom_addr 0x00000, 0x00001; both produce correct cw.
- Assert RST in RD_HI → outputs immediately cw=0, cw_valid=0, stall=1, miss_count=0. After release, the next pc causes a normal 3-cycle fill.
